// File: rtl/symm_decorr_iter_if.sv
// Link between symm_decorr_iter and its W*W'*W multiply stage:
// enable and current W out, registered 0.5*W*W'*W back one clock later.
interface symm_decorr_iter_if;
  logic         mul_en;
  logic [415:0] mul_w;
  logic [415:0] mul_res;

  modport master (output mul_en, output mul_w, input mul_res);
  modport slave  (input mul_en, input mul_w, output mul_res);
endinterface

// File: rtl/symm_decorr_iter.sv
// Iterative symmetric decorrelation of a 4x4 Q13 W: W <- 1.5W - 0.5*W*W'*W until max|dW| <= TOL.
// Define SYMM_DECORR_SAT_EN to saturate updated elements to 26 bits instead of wrapping.
module symm_decorr_iter #(
  parameter int unsigned TOL      = 8,
  parameter int unsigned MAX_ITER = 16
) (
  input  logic               clk_sdec,
  input  logic               rstn_sdec,
  input  logic               start_sdec,
  input  logic [415:0]       w_in,
  symm_decorr_iter_if.master mul_bus,
  output logic [415:0]       w_out,
  output logic               done,
  output logic               converged,
  output logic [7:0]         iter_cnt,
  output logic               busy
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_UPD, S_CHK, S_DONE} state_t;

  state_t       state, state_nxt;
  logic [415:0] w_q, w_nxt;
  logic [27:0]  maxd_q, maxd_nxt;
  logic [7:0]   iter_q;
  logic         conv_q;
  logic         tol_met;
  logic         mul_en_c;

  logic signed [25:0] w_old, w_half, res_e, n26;
  logic signed [27:0] n28;
  logic signed [26:0] diff;
  logic [27:0]        ext, absd;

  assign tol_met = ({4'd0, maxd_q} <= TOL);

  // Element-wise update and largest-change search over all 16 elements.
  always_comb begin
    w_nxt    = '0;
    maxd_nxt = '0;
    w_old    = '0;
    w_half   = '0;
    res_e    = '0;
    n28      = '0;
    n26      = '0;
    diff     = '0;
    ext      = '0;
    absd     = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      w_old  = w_q[26*i +: 26];
      res_e  = mul_bus.mul_res[26*i +: 26];
      w_half = w_old >>> 1;
      n28    = {{2{w_old[25]}}, w_old} + {{2{w_half[25]}}, w_half}
             - {{2{res_e[25]}}, res_e};
`ifdef SYMM_DECORR_SAT_EN
      if (n28[27:25] != 3'b000 && n28[27:25] != 3'b111)
        n26 = n28[27] ? {1'b1, 25'd0} : {1'b0, {25{1'b1}}};
      else
        n26 = n28[25:0];
`else
      n26 = n28[25:0];
`endif
      diff = {n26[25], n26} - {w_old[25], w_old};
      // Widened to 28 bits so the most negative 27-bit difference has a magnitude.
      ext  = {diff[26], diff};
      absd = ext[27] ? (28'd0 - ext) : ext;
      w_nxt[26*i +: 26] = n26;
      if (absd > maxd_nxt)
        maxd_nxt = absd;
    end
  end

  always_comb begin
    state_nxt = state;
    mul_en_c  = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start_sdec)
          state_nxt = S_MUL;
      end
      S_MUL: begin
        mul_en_c  = 1'b1;
        state_nxt = S_UPD;
      end
      S_UPD: state_nxt = S_CHK;
      S_CHK: begin
        if (tol_met || iter_q == 8'(MAX_ITER))
          state_nxt = S_DONE;
        else
          state_nxt = S_MUL;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sdec or negedge rstn_sdec) begin
    if (!rstn_sdec) begin
      state  <= S_IDLE;
      w_q    <= '0;
      maxd_q <= '0;
      iter_q <= '0;
      conv_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start_sdec) begin
        w_q    <= w_in;
        iter_q <= '0;
        conv_q <= 1'b0;
      end
      if (state == S_UPD) begin
        w_q    <= w_nxt;
        maxd_q <= maxd_nxt;
        iter_q <= iter_q + 8'd1;
      end
      if (state == S_CHK && tol_met)
        conv_q <= 1'b1;
    end
  end

  assign mul_bus.mul_en = mul_en_c;
  assign mul_bus.mul_w  = w_q;
  assign w_out          = w_q;
  assign converged      = conv_q;
  assign iter_cnt       = iter_q;

endmodule

// File: tb/tb_symm_decorr_iter.sv
// Directed bench for symm_decorr_iter: real multiply-stage model on dut_a, zero-result stub on dut_b.
module tb_symm_decorr_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn, start_a, start_b;
  logic [415:0] w_in_a, w_in_b, w_out_a, w_out_b;
  logic         done_a, done_b, conv_a, conv_b, busy_a, busy_b;
  logic [7:0]   iter_a, iter_b;
  int           errors = 0;
  int           checks = 0;

  symm_decorr_iter_if bus_a ();
  symm_decorr_iter_if bus_b ();

  symm_decorr_iter #(.TOL(8), .MAX_ITER(16)) dut_a (
    .clk_sdec(clk), .rstn_sdec(rstn), .start_sdec(start_a), .w_in(w_in_a),
    .mul_bus(bus_a), .w_out(w_out_a), .done(done_a), .converged(conv_a),
    .iter_cnt(iter_a), .busy(busy_a));

  symm_decorr_iter #(.TOL(8), .MAX_ITER(2)) dut_b (
    .clk_sdec(clk), .rstn_sdec(rstn), .start_sdec(start_b), .w_in(w_in_b),
    .mul_bus(bus_b), .w_out(w_out_b), .done(done_b), .converged(conv_b),
    .iter_cnt(iter_b), .busy(busy_b));

  function automatic logic [415:0] mul_model(input logic [415:0] w);
    longint m [4][4];
    longint a [4][4];
    longint s;
    logic [415:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[i][j] = longint'($signed(w[26*(4*i+j) +: 26]));
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += m[i][k] * m[j][k];
        a[i][j] = s >>> 13;
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += a[i][k] * m[k][j];
        s = (s >>> 13) >>> 1;
        r[26*(4*i+j) +: 26] = s[25:0];
      end
    return r;
  endfunction

  always @(posedge clk)
    if (bus_a.mul_en) bus_a.mul_res <= mul_model(bus_a.mul_w);
  assign bus_b.mul_res = '0;

  function automatic logic [415:0] diag(input logic signed [25:0] v);
    logic [415:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[26*5*i +: 26] = v;
    return r;
  endfunction

  function automatic logic signed [25:0] el(input logic [415:0] w, input int idx);
    return w[26*idx +: 26];
  endfunction

  task tick;
    @(posedge clk);
    #1;
  endtask

  task test_reset;
    #2;
    checks++; if (w_out_a !== '0) begin errors++; $display("FAIL reset_w_out: got %h want 0", w_out_a); end
    checks++; if (bus_a.mul_w !== '0) begin errors++; $display("FAIL reset_mul_w: got %h want 0", bus_a.mul_w); end
    checks++; if ({bus_a.mul_en, done_a, busy_a, conv_a} !== 4'b0) begin errors++;
      $display("FAIL reset_flags: got en/done/busy/conv=%b want 0000", {bus_a.mul_en, done_a, busy_a, conv_a}); end
    checks++; if (iter_a !== 8'd0) begin errors++; $display("FAIL reset_iter: got %0d want 0", iter_a); end
    checks++; if ({w_out_b, done_b, busy_b} !== '0) begin errors++; $display("FAIL reset_dut_b: outputs not all 0"); end
    tick; tick;
    rstn = 1'b1;
    tick;
  endtask

  task test_identity;
    int cyc;
    w_in_a = diag(26'sd8192);
    start_a = 1'b1; tick; start_a = 1'b0; cyc = 1;
    checks++; if (bus_a.mul_en !== 1'b1) begin errors++; $display("FAIL ident_mul_en: got %b want 1", bus_a.mul_en); end
    checks++; if (bus_a.mul_w !== diag(26'sd8192)) begin errors++; $display("FAIL ident_mul_w: got %h", bus_a.mul_w); end
    checks++; if (iter_a !== 8'd0) begin errors++; $display("FAIL ident_iter_c1: got %0d want 0", iter_a); end
    while (done_a !== 1'b1 && cyc < 100) begin tick; cyc++; end
    checks++; if (cyc != 4) begin errors++; $display("FAIL ident_done_cycle: got %0d want 4", cyc); end
    checks++; if (conv_a !== 1'b1) begin errors++; $display("FAIL ident_conv: got %b want 1", conv_a); end
    checks++; if (iter_a !== 8'd1) begin errors++; $display("FAIL ident_iter: got %0d want 1", iter_a); end
    checks++; if (w_out_a !== diag(26'sd8192)) begin errors++; $display("FAIL ident_w_out: got %h", w_out_a); end
    tick;
    checks++; if ({done_a, busy_a} !== 2'b00) begin errors++; $display("FAIL ident_after: done/busy=%b want 00", {done_a, busy_a}); end
  endtask

  task test_half;
    int cyc;
    w_in_a = diag(26'sd4096);
    start_a = 1'b1; tick; start_a = 1'b0; cyc = 1;
    tick; tick; cyc = 3;
    checks++; if (w_out_a !== diag(26'sd5632)) begin errors++; $display("FAIL half_iter1: got w11=%0d want 5632", el(w_out_a, 0)); end
    checks++; if (bus_a.mul_w !== diag(26'sd5632)) begin errors++; $display("FAIL half_mul_w: got w11=%0d want 5632", el(bus_a.mul_w, 0)); end
    while (done_a !== 1'b1 && cyc < 200) begin tick; cyc++; end
    checks++; if (cyc != 16) begin errors++; $display("FAIL half_done_cycle: got %0d want 16", cyc); end
    checks++; if (conv_a !== 1'b1) begin errors++; $display("FAIL half_conv: got %b want 1", conv_a); end
    checks++; if (iter_a !== 8'd5) begin errors++; $display("FAIL half_iter: got %0d want 5", iter_a); end
    checks++; if (el(w_out_a, 15) < 8184 || el(w_out_a, 15) > 8200) begin errors++;
      $display("FAIL half_final: got w44=%0d want 8192+-8", el(w_out_a, 15)); end
  endtask

  task test_stub_cap;
    int cyc;
    w_in_b = diag(26'sd8192);
    start_b = 1'b1; tick; start_b = 1'b0;
    tick; tick; cyc = 3;
    checks++; if (w_out_b !== diag(26'sd12288)) begin errors++; $display("FAIL cap_iter1: got w11=%0d want 12288", el(w_out_b, 0)); end
    while (done_b !== 1'b1 && cyc < 100) begin tick; cyc++; end
    checks++; if (cyc != 7) begin errors++; $display("FAIL cap_done_cycle: got %0d want 7", cyc); end
    checks++; if (conv_b !== 1'b0) begin errors++; $display("FAIL cap_conv: got %b want 0", conv_b); end
    checks++; if (iter_b !== 8'd2) begin errors++; $display("FAIL cap_iter: got %0d want 2", iter_b); end
    checks++; if (w_out_b !== diag(26'sd18432)) begin errors++; $display("FAIL cap_w_out: got w11=%0d want 18432", el(w_out_b, 0)); end
    tick;
  endtask

  task test_saturation;
    int cyc;
    logic signed [25:0] exp_w11;
`ifdef SYMM_DECORR_SAT_EN
    exp_w11 = 26'sd33554431;
`else
    exp_w11 = -26'sd29360128;
`endif
    w_in_b = '0;
    w_in_b[25:0] = 26'sd25165824;
    start_b = 1'b1; tick; start_b = 1'b0;
    tick; tick; cyc = 3;
    checks++; if (el(w_out_b, 0) !== exp_w11) begin errors++; $display("FAIL sat_w11: got %0d want %0d", el(w_out_b, 0), exp_w11); end
    checks++; if (w_out_b[415:26] !== '0) begin errors++; $display("FAIL sat_others: nonzero elements %h", w_out_b[415:26]); end
    while (done_b !== 1'b1 && cyc < 100) begin tick; cyc++; end
    checks++; if (cyc != 7 || conv_b !== 1'b0) begin errors++; $display("FAIL sat_done: got cycle %0d conv %b want 7 0", cyc, conv_b); end
    tick;
  endtask

  task test_reset_mid;
    int cyc;
    int nd;
    w_in_a = diag(26'sd4096);
    start_a = 1'b1; tick; start_a = 1'b0;
    tick; tick; tick; tick;
    checks++; if (iter_a !== 8'd1 || busy_a !== 1'b1 || bus_a.mul_en !== 1'b0) begin errors++;
      $display("FAIL mid_pre: got iter %0d busy %b en %b want 1 1 0", iter_a, busy_a, bus_a.mul_en); end
    #1 rstn = 1'b0;
    #1;
    checks++; if (w_out_a !== '0 || bus_a.mul_w !== '0) begin errors++; $display("FAIL mid_w_clear: w_out %h", w_out_a); end
    checks++; if ({busy_a, done_a, conv_a, iter_a} !== 11'd0) begin errors++;
      $display("FAIL mid_flags: busy %b done %b conv %b iter %0d want all 0", busy_a, done_a, conv_a, iter_a); end
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) rstn = 1'b1;
      tick;
      if (done_a === 1'b1) nd++;
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL mid_no_done: got %0d done pulses want 0", nd); end
    w_in_a = diag(26'sd8192);
    start_a = 1'b1; tick; start_a = 1'b0; cyc = 1;
    checks++; if (iter_a !== 8'd0 || bus_a.mul_en !== 1'b1) begin errors++;
      $display("FAIL mid_restart: got iter %0d en %b want 0 1", iter_a, bus_a.mul_en); end
    while (done_a !== 1'b1 && cyc < 100) begin tick; cyc++; end
    checks++; if (cyc != 4 || iter_a !== 8'd1) begin errors++; $display("FAIL mid_rerun: got cycle %0d iter %0d want 4 1", cyc, iter_a); end
    tick;
  endtask

  task test_back_to_back;
    int cyc;
    int nd;
    w_in_a = diag(26'sd8192);
    start_a = 1'b1; tick; cyc = 1; nd = 0;
    while (cyc < 5) begin tick; cyc++; if (done_a === 1'b1) nd++; end
    checks++; if (nd != 1) begin errors++; $display("FAIL b2b_one_done: got %0d want 1", nd); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_done_start_ignored: busy %b want 0", busy_a); end
    tick; start_a = 1'b0; cyc = 1;
    checks++; if (busy_a !== 1'b1 || bus_a.mul_en !== 1'b1) begin errors++;
      $display("FAIL b2b_next_start: busy %b en %b want 1 1", busy_a, bus_a.mul_en); end
    while (done_a !== 1'b1 && cyc < 100) begin tick; cyc++; end
    checks++; if (cyc != 4) begin errors++; $display("FAIL b2b_second_run: done cycle %0d want 4", cyc); end
    tick;
  endtask

  initial begin
    rstn = 1'b0; start_a = 1'b0; start_b = 1'b0;
    w_in_a = '0; w_in_b = '0;
    test_reset;
    test_identity;
    test_half;
    test_stub_cap;
    test_saturation;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/symm_decorr_iter.md
# symm_decorr_iter

Iterative symmetric-decorrelation controller for the FastICA unmixing matrix. It holds the 4×4 Q13 weight matrix W and drives the neighbouring W·Wᵀ·W stage, which returns 0.5·W·Wᵀ·W one clock after its enable. Each iteration it applies W ← 1.5·W − 0.5·W·Wᵀ·W, measures the largest element change, and repeats until that change is within tolerance or an iteration cap is reached. It sits directly upstream of the multiply stage, owns that stage's enable, and consumes its registered result.

## Interface
- TOL, 8: convergence threshold in Q13 LSBs. Converged when max |ΔW| ≤ TOL.
- MAX_ITER, 16: iteration cap, range 1–255.
- clk_sdec  in  1  clock, rising edge.
- rstn_sdec  in  1  reset; one clock, asynchronous active-low reset.
- start_sdec  in  1  single-cycle request. Sampled only in IDLE.
- w_in  in  416  initial W, 16 signed 26-bit Q13 elements. Element rc is at bits [26·(4(r−1)+(c−1)) +: 26].
- mul_en  out  1  enable to the multiply stage. High for exactly one cycle per iteration.
- mul_w  out  416  current W presented to the multiply stage. Same packing as w_in.
- mul_res  in  416  0.5·W·Wᵀ·W from the multiply stage. Valid in the cycle after mul_en.
- w_out  out  416  current W. Final value is valid while done is high and holds until the next start.
- done  out  1  one-cycle pulse when the run ends.
- converged  out  1  set with done if the tolerance was met; held until the next start.
- iter_cnt  out  8  number of iterations completed in this run.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, MUL, UPD, CHK, DONE. Reset enters IDLE.
- IDLE:
  - On start_sdec, load W from w_in, clear iter_cnt and converged, go to MUL.
  - busy, mul_en and done are 0 in IDLE.
- MUL: mul_en = 1, mul_w = W. Go to UPD.
- UPD: for each element:
  - n = W + (W >>> 1) − mul_res, computed at 28 bits signed.
  - Reduce n to 26 bits (see Configuration) and register it into W.
  - d = |n₂₆ − W_old|, computed at 27 bits. Register the maximum over all 16 elements as maxd.
  - Increment iter_cnt. Go to CHK.
- CHK:
  - If maxd ≤ TOL: set converged = 1, go to DONE.
  - Else if iter_cnt == MAX_ITER: leave converged = 0, go to DONE.
  - Else go to MUL.
- DONE: done = 1 for one cycle, then go to IDLE.
- start_sdec while busy is ignored. No queuing.
- mul_w always equals W. It changes only on the edge that leaves IDLE with start or the edge that leaves UPD.
- The absolute value of the most negative 27-bit difference is taken at 28 bits; it never wraps.

## Timing
- Reset (asynchronous, immediate): W = 0, maxd = 0, iter_cnt = 0, state IDLE.
  - All outputs 0 during and after reset, including mul_w and w_out.
- Reset asserted mid-run aborts the run. No done pulse is produced.
- Each iteration takes 3 cycles (MUL, UPD, CHK).
- done is high in cycle 3k+1 after the start edge, where k is the final iter_cnt. For k = 1, done is high in cycle 4.
- The multiply stage latency is fixed at 1 clock.
- mul_res is sampled only in UPD. Its value in other cycles is ignored.
- A start_sdec in the same cycle as done is ignored (state is DONE). A new start is accepted from the next cycle onward.

## Configuration
- SYMM_DECORR_SAT_EN:
  - Defined: the 28-bit n saturates to the 26-bit range [−33554432, 33554431].
  - Undefined: n is truncated to bits [25:0], so it wraps.
  - The maxd computation uses the reduced 26-bit value in both builds.

## Test plan
- Identity W (diagonals 8192, rest 0), real multiply stage → mul_res diagonals 4096, W unchanged, maxd 0; done in cycle 4, converged = 1, iter_cnt = 1.
- W = 0.5·I (diagonals 4096) → after iteration 1 the diagonals are 5632 (maxd 1536). The run continues and converges to 8192±TOL with converged = 1 and iter_cnt < 16.
- Stub that forces mul_res = 0 with W = 8192·I, MAX_ITER = 2 → diagonals grow 12288, then 18432. done with converged = 0, iter_cnt = 2, done in cycle 7.
- Stub with mul_res = 0 and w11 = 25165824 → with SYMM_DECORR_SAT_EN, w11 = 33554431; without it, w11 = 37748736 − 2²⁶ = −29360128.
- Reset pulse in UPD of iteration 2 → all outputs 0 immediately, no done pulse. A new start then runs a full sequence from iter_cnt = 0.
- start_sdec held high through a whole run → exactly one run and one done pulse. The start in the done cycle is ignored; a start in the next cycle begins a new run.
